program_counter: RTL and testbench
==================================

// Module: program_counter
//
// PURPOSE
// - Program-counter register of the RISC-V (RV32I) core datapath.
// - Holds the address of the instruction currently being fetched; drives the
//   instruction-memory address and the PC+4 / branch-target adders.
// - Loads the next-PC value (from the next-PC mux upstream) every clock.
// - Returns to a fixed reset vector on reset.
//
// PARAMETERS
// - WIDTH         default 32             address width in bits; (WIDTH >= 2)
// - RESET_VECTOR  default 32'h0000_0000  value loaded on reset; bits [1:0] must be 0
//
// PORTS
// - clk       in   1      single clock; all state updates on the rising edge
// - rst       in   1      reset; synchronous, active-low (0 = reset asserted)
// - data_in   in   WIDTH  next PC value, from the next-PC mux
// - data_out  out  WIDTH  current PC, registered output
//
// BEHAVIOUR
// - One clock (clk); reset is synchronous and active-low on rst.
// - rst is sampled only at the rising edge of clk.
//   There is no asynchronous path.
// - Rising edge with rst==0: data_out <= RESET_VECTOR.
//   - data_in is ignored on that edge.
// - Rising edge with rst==1: data_out <= data_in.
//   - data_in is sampled at that edge.
// - Latency: exactly 1 cycle, data_in -> data_out.
//   - No enable or stall: the PC loads on every non-reset edge.
// - data_out is a pure register output with no combinational path from any input.
//   - It changes only just after a rising clk edge.
// - Power-up, before the first reset edge: data_out is X.
//   - Consumers must apply reset before use.
// - Reset mid-run: the next edge with rst==0 forces RESET_VECTOR, whatever the
//   prior value or the data_in value.
//   - The first edge with rst==1 after that loads data_in.
// - rst or data_in changing between edges: no effect until the next rising edge.
// - Width/values:
//   - No arithmetic inside the block; PC+4 is computed externally.
//   - All values 0 .. 2^WIDTH-1 are loaded verbatim, including wrap values such
//     as 32'hFFFF_FFFC -> 32'h0000_0000 coming from the adder.
//
// CONFIGURATION
// - Macro PC_ALIGN_EN:
//   - Defined: the loaded value is {data_in[WIDTH-1:2], 2'b00}.
//     - data_out[1:0] is always 0; instruction alignment is enforced.
//   - Not defined: data_in is loaded unmodified, with all bits kept.
//   - Reset behaviour is identical in both builds (RESET_VECTOR).
//
// TESTING
// - Reset:
//   - rst=0, data_in=32'h1234_5678, one rising edge -> data_out==32'h0000_0000.
// - Load:
//   - rst=1, data_in=32'h0000_0004, one edge -> data_out==32'h0000_0004.
//   - data_out holds that value until the next edge.
// - Sequence:
//   - rst=1, data_in=32'h0000_0008, 32'h0000_000C, 32'h0000_0100 on successive
//     edges -> data_out follows them, one cycle delayed.
// - Synchronous reset check:
//   - Drop rst to 0 between edges while data_out==32'h0000_0100 -> data_out
//     stays 32'h0000_0100 until the next edge, then becomes 32'h0000_0000.
// - Alignment:
//   - rst=1, data_in=32'hDEAD_BEEF:
//     - PC_ALIGN_EN defined -> 32'hDEAD_BEEC.
//     - PC_ALIGN_EN not defined -> 32'hDEAD_BEEF.
// - Random soak:
//   - Drive rst/data_in with $random every 25 time units against a 20-unit clock
//     period, at least 25 iterations.
//   - Check on every edge against a reference model: rst ? data_in : RESET_VECTOR.

Source files
------------

// File: rtl/program_counter.sv
// program_counter: RV32I PC register; 1-cycle latency data_in -> data_out; no backpressure, loads every edge.
// Build option PC_ALIGN_EN: when defined, loaded values have bits [1:0] forced to zero.
module program_counter #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] load_val;

`ifdef PC_ALIGN_EN
  // Bit clear rather than a slice so WIDTH == 2 still elaborates cleanly.
  always_comb begin
    load_val      = data_in;
    load_val[1:0] = 2'b00;
  end
`else
  always_comb begin
    load_val = data_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= RESET_VECTOR;
    end else begin
      data_out <= load_val;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed and random checks of program_counter; expected values follow the PC_ALIGN_EN build.
module tb_program_counter;

  localparam int unsigned      WIDTH = 32;
  localparam logic [WIDTH-1:0] RV    = 32'h0000_0000;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] aligned(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
`ifdef PC_ALIGN_EN
    r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst     = 1'b0;
    data_in = 32'h1234_5678;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset: data_out=%h expected %h", data_out, 32'h0000_0000);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    rst     = 1'b1;
    data_in = 32'h0000_0004;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL load: data_out=%h expected %h", data_out, 32'h0000_0004);
    end
    // Changing data_in between edges must not reach the output.
    @(negedge clk);
    data_in = 32'h0000_0FF0;
    #5;
    n_checks++;
    if (data_out !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL load_hold: data_out=%h expected %h", data_out, 32'h0000_0004);
    end
  endtask

  task automatic test_sequence();
    logic [WIDTH-1:0] seq [3];
    logic [WIDTH-1:0] prev;
    seq[0] = 32'h0000_0008;
    seq[1] = 32'h0000_000C;
    seq[2] = 32'h0000_0100;
    prev   = 32'h0000_0FF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = seq[i];
      #2;
      n_checks++;
      if (data_out !== prev) begin
        n_fail++;
        $display("FAIL seq_pre[%0d]: data_out=%h expected %h", i, data_out, prev);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (data_out !== seq[i]) begin
        n_fail++;
        $display("FAIL seq[%0d]: data_out=%h expected %h", i, data_out, seq[i]);
      end
      prev = seq[i];
    end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    rst     = 1'b0;
    data_in = 32'hAAAA_5554;
    #2;
    n_checks++;
    if (data_out !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL sync_rst_pre: data_out=%h expected %h", data_out, 32'h0000_0100);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== RV) begin
      n_fail++;
      $display("FAIL sync_rst: data_out=%h expected %h", data_out, RV);
    end
    @(negedge clk);
    data_in = 32'h5555_0008;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== RV) begin
      n_fail++;
      $display("FAIL sync_rst_held: data_out=%h expected %h", data_out, RV);
    end
    @(negedge clk);
    rst     = 1'b1;
    data_in = 32'h0000_0040;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL rst_release: data_out=%h expected %h", data_out, 32'h0000_0040);
    end
  endtask

  task automatic test_alignment();
    logic [WIDTH-1:0] exp_v;
`ifdef PC_ALIGN_EN
    exp_v = 32'hDEAD_BEEC;
`else
    exp_v = 32'hDEAD_BEEF;
`endif
    @(negedge clk);
    rst     = 1'b1;
    data_in = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== exp_v) begin
      n_fail++;
      $display("FAIL align: data_out=%h expected %h", data_out, exp_v);
    end
    @(negedge clk);
    data_in = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: data_out=%h expected %h", data_out, 32'hFFFF_FFFC);
    end
    @(negedge clk);
    data_in = 32'h0000_0000;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_zero: data_out=%h expected %h", data_out, 32'h0000_0000);
    end
  endtask

  task automatic test_random_soak();
    logic [WIDTH-1:0] exp_v;
    @(negedge clk);
    // Offset so the 25-unit input changes never land on a clock edge.
    #2;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          rst     = 1'($random);
          data_in = $random;
          #25;
        end
      end
      begin
        for (int e = 0; e < 36; e++) begin
          @(posedge clk);
          exp_v = rst ? aligned(data_in) : RV;
          #1;
          n_checks++;
          if (data_out !== exp_v) begin
            n_fail++;
            $display("FAIL soak[%0d]: data_out=%h expected %h", e, data_out, exp_v);
          end
        end
      end
    join
  endtask

  initial begin
    rst     = 1'b1;
    data_in = '0;
    test_reset();
    test_load();
    test_sequence();
    test_sync_reset();
    test_alignment();
    test_random_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
